simon_key_sched: RTL and testbench
==================================

SIMON_KEY_SCHED -- requirements
Module: simon_key_sched

Interface
REQ-001 Parameter WORD_W, default 16: key/round-key word width (Simon 32/64).
REQ-002 Parameter ROUNDS, default 32: number of round keys generated and stored.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 res_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request key expansion of key_in; sampled in IDLE and DONE only.
REQ-006 key_in  input  64  master key; key_in[15:0]=k0, [31:16]=k1, [47:32]=k2, [63:48]=k3.
REQ-007 key_done  output  1  high while all ROUNDS round keys are valid; feeds the control FSM's key_done.
REQ-008 rd_en  input  1  round-key read request.
REQ-009 rd_idx  input  5  round-key index to read; encrypt reads ascending, decrypt reads 31-r.
REQ-010 rk_out  output  16  registered round key.
REQ-011 rk_valid  output  1  high for one cycle when rk_out carries a requested key.

Function
REQ-012 States: IDLE, GEN, DONE; one-hot or binary at implementer's choice.
REQ-013 IDLE, start=1: load window w0..w3 <= k0..k3, idx <= 0, go to GEN; start=0: stay.
REQ-014 Each GEN cycle: write w0 to rk_mem[idx]; shift window w0<=w1, w1<=w2, w2<=w3, w3<=new; idx <= idx+1.
REQ-015 New word: tmp = ROR3(w3) ^ w1; tmp = tmp ^ ROR1(tmp); new = 16'hFFFC ^ z0[idx] ^ w0 ^ tmp (z0[idx] XORed into bit 0).
REQ-016 z0 is the 62-bit Simon sequence 11111010001001010110000111001101111101000100101011000011100110, bit 0 leftmost; idx never exceeds 31, so no wrap occurs.
REQ-017 GEN with idx=31: write final entry, go to DONE; GEN lasts exactly 32 cycles.
REQ-018 Latency: start accepted at edge T -> GEN occupies edges T+1..T+32 -> key_done=1 after edge T+32.
REQ-019 key_done = 1 exactly in DONE; stays high until restart or reset.
REQ-020 start ignored in GEN; no abort, no re-capture of key_in.
REQ-021 DONE, start=1: behave as REQ-013 (reload, key_done falls after that edge); stored keys are overwritten progressively.
REQ-022 Read: rd_en=1 in DONE -> next edge rk_out <= rk_mem[rd_idx], rk_valid <= 1; one-cycle latency, one read per cycle, back-to-back allowed.
REQ-023 rd_en outside DONE -> rk_valid <= 0, rk_out holds previous value.
REQ-024 rd_en and start both high in DONE: read is serviced (old contents), restart also taken.
REQ-025 rd_idx is 5 bits; all values 0..31 legal, no out-of-range case.

Reset
REQ-026 res_n=0 asynchronously forces IDLE, idx=0, key_done=0, rk_valid=0, rk_out=0, window=0.
REQ-027 rk_mem not reset; contents undefined until a full GEN completes.
REQ-028 Reset mid-GEN aborts expansion; after release, block stays in IDLE until start.

Structure
REQ-029 Shared package/include simon_pkg holds Z0 constant, WORD_W, ROUNDS, key constant 16'hFFFC and state encodings.
REQ-030 Storage is sub-module simon_rk_ram: 32x16, one synchronous write port, one registered read port.
REQ-031 Round-function logic of REQ-015 stays inline in simon_key_sched.

Verification
REQ-032 Reset, then key_in=64'h1918_1110_0908_0100, start one cycle -> key_done rises exactly 32 cycles after the accept edge.
REQ-033 Same key, read rd_idx 0..4 -> rk_out 16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h71C3, rk_valid one cycle after each rd_en.
REQ-034 Read all 32 indices, ascending and then descending (31..0) -> match software Simon 32/64 model, including rk[31].
REQ-035 start pulsed at cycle 10 of GEN with a different key_in -> ignored; results equal the first key's.
REQ-036 res_n asserted at GEN cycle 15 -> outputs zero immediately; stays IDLE; new start yields correct full schedule.
REQ-037 rd_en in IDLE/GEN -> rk_valid=0; rd_en+start together in DONE -> old key returned, key_done drops next cycle.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared constants and types for the Simon 32/64 key schedule.
package simon_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ROUNDS = 32;
  localparam int unsigned IDX_W  = 5;

  localparam logic [WORD_W-1:0] RK_CONST = 16'hFFFC;

  // Ascending range so that Z0[0] is the leftmost (first) sequence bit.
  localparam logic [0:61] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/simon_key_sched_if.sv
// Control/read bus between the key schedule and its consumer.
interface simon_key_sched_if;
  import simon_pkg::*;

  logic                  start;
  logic [4*WORD_W-1:0]   key_in;
  logic                  key_done;
  logic                  rd_en;
  logic [IDX_W-1:0]      rd_idx;
  logic [WORD_W-1:0]     rk_out;
  logic                  rk_valid;

  modport master (
    output start, key_in, rd_en, rd_idx,
    input  key_done, rk_out, rk_valid
  );

  modport slave (
    input  start, key_in, rd_en, rd_idx,
    output key_done, rk_out, rk_valid
  );

endinterface

// File: rtl/simon_rk_ram.sv
// Round-key store: one synchronous write port, one registered read port.
module simon_rk_ram #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata_q
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_d;

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: rtl/simon_key_sched.sv
// Simon 32/64 key expansion: generates ROUNDS round keys into a RAM, then serves reads.
module simon_key_sched #(
    parameter int unsigned WORD_W = simon_pkg::WORD_W,
    parameter int unsigned ROUNDS = simon_pkg::ROUNDS
) (
    input  logic               clk,
    input  logic               res_n,
    simon_key_sched_if.slave   bus
);
    import simon_pkg::*;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [3:0][WORD_W-1:0]   w_q, w_d;
    logic                     rk_valid_q, rk_valid_d;
    logic [WORD_W-1:0]        tmp_a, tmp_b, new_w;
    logic                     we;
    logic                     rd_fire;

    always_comb begin
        tmp_a = {w_q[3][2:0], w_q[3][WORD_W-1:3]} ^ w_q[1];
        tmp_b = tmp_a ^ {tmp_a[0], tmp_a[WORD_W-1:1]};
        new_w = WORD_W'(RK_CONST) ^ w_q[0] ^ tmp_b ^ WORD_W'(Z0[{1'b0, idx_q}]);

        state_d = state_q;
        idx_d   = idx_q;
        w_d     = w_q;
        we      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_d     = bus.key_in;
                    idx_d   = '0;
                    state_d = ST_GEN;
                end
            end
            ST_GEN: begin
                we    = 1'b1;
                w_d   = {new_w, w_q[3], w_q[2], w_q[1]};
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(ROUNDS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A read in DONE sees pre-restart contents: GEN writes start one edge later.
        rd_fire    = bus.rd_en && (state_q == ST_DONE);
        rk_valid_d = rd_fire;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            w_q        <= '0;
            rk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            w_q        <= w_d;
            rk_valid_q <= rk_valid_d;
        end
    end

    simon_rk_ram #(
        .DEPTH (ROUNDS),
        .WIDTH (WORD_W),
        .AW    (IDX_W)
    ) u_rk_ram (
        .clk     (clk),
        .res_n   (res_n),
        .we      (we),
        .waddr   (idx_q),
        .wdata   (w_q[0]),
        .re      (rd_fire),
        .raddr   (bus.rd_idx),
        .rdata_q (bus.rk_out)
    );

    assign bus.key_done = (state_q == ST_DONE);
    assign bus.rk_valid = rk_valid_q;

endmodule

// File: tb/tb_simon_key_sched.sv
// Self-checking bench for simon_key_sched against a software Simon 32/64 key schedule.
module tb_simon_key_sched;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    always #5 clk = ~clk;

    simon_key_sched_if bus ();

    simon_key_sched #(
        .WORD_W (16),
        .ROUNDS (32)
    ) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_rk [32];
    logic [15:0] obs_rk [32];
    logic        obs_v  [32];
    logic [15:0] last_rk;
    string       z_seq = "11111010001001010110000111001101111101000100101011000011100110";

    function automatic logic [15:0] ror16(input logic [15:0] x, input int n);
        return (x >> n) | (x << (16 - n));
    endfunction

    // Reference: textbook form k[i] = ~k[i-4] ^ tmp ^ 3 ^ z[i-4].
    task automatic build_model(input logic [63:0] key);
        logic [15:0] tmp;
        for (int i = 0; i < 4; i++) exp_rk[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp = ror16(exp_rk[i-1], 3) ^ exp_rk[i-3];
            tmp = tmp ^ ror16(tmp, 1);
            exp_rk[i] = ~exp_rk[i-4] ^ tmp ^ 16'h0003 ^ ((z_seq[i-4] == "1") ? 16'h0001 : 16'h0000);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_key(input logic [63:0] key);
        bus.start  = 1'b1;
        bus.key_in = key;
        tick();
        bus.start  = 1'b0;
        bus.key_in = {$urandom, $urandom};
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.key_done === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic read_all(input bit ascending);
        int idx;
        for (int k = 0; k < 32; k++) begin
            idx = ascending ? k : 31 - k;
            bus.rd_en  = 1'b1;
            bus.rd_idx = 5'(idx);
            tick();
            obs_rk[idx] = bus.rk_out;
            obs_v[idx]  = bus.rk_valid;
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.key_done !== 1'b0 || bus.rk_valid !== 1'b0 || bus.rk_out !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: key_done=%b rk_valid=%b rk_out=%h, required 0/0/0000",
                     bus.key_done, bus.rk_valid, bus.rk_out);
        end
        res_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.key_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stays_idle: key_done=%b, required 0", bus.key_done);
        end
    endtask

    task automatic test_latency();
        int cyc;
        start_key(64'h1918_1110_0908_0100);
        build_model(64'h1918_1110_0908_0100);
        wait_done(cyc);
        n_checks++;
        if (cyc != 32) begin
            n_fail++;
            $display("FAIL done_latency: key_done after %0d edges, required 32", cyc);
        end
        tick();
        tick();
        n_checks++;
        if (bus.key_done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_held: key_done=%b, required 1", bus.key_done);
        end
    endtask

    task automatic test_known_vector();
        logic [15:0] kv [5];
        kv[0] = 16'h0100; kv[1] = 16'h0908; kv[2] = 16'h1110;
        kv[3] = 16'h1918; kv[4] = 16'h71C3;
        for (int i = 0; i < 5; i++) begin
            bus.rd_en  = 1'b1;
            bus.rd_idx = 5'(i);
            tick();
            bus.rd_en = 1'b0;
            n_checks++;
            if (bus.rk_valid !== 1'b1 || bus.rk_out !== kv[i]) begin
                n_fail++;
                $display("FAIL known_rk%0d: rk_out=%h valid=%b, required %h valid=1",
                         i, bus.rk_out, bus.rk_valid, kv[i]);
            end
            tick();
            n_checks++;
            if (bus.rk_valid !== 1'b0 || bus.rk_out !== kv[i]) begin
                n_fail++;
                $display("FAIL known_hold%0d: rk_out=%h valid=%b, required %h valid=0",
                         i, bus.rk_out, bus.rk_valid, kv[i]);
            end
        end
    endtask

    task automatic test_full_read();
        for (int dir = 1; dir >= 0; dir--) begin
            read_all(dir[0]);
            for (int i = 0; i < 32; i++) begin
                n_checks++;
                if (obs_rk[i] !== exp_rk[i] || obs_v[i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_read dir=%0d rk%0d: got %h valid=%b, required %h valid=1",
                             dir, i, obs_rk[i], obs_v[i], exp_rk[i]);
                end
            end
        end
        last_rk = exp_rk[0];
    endtask

    task automatic test_read_outside_done();
        logic [63:0] key;
        int cyc;
        key = {$urandom, $urandom};
        start_key(key);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.rd_idx = 5'($urandom_range(0, 31));
            tick();
            n_checks++;
            if (bus.rk_valid !== 1'b0 || bus.rk_out !== last_rk) begin
                n_fail++;
                $display("FAIL read_in_gen%0d: rk_out=%h valid=%b, required %h valid=0",
                         i, bus.rk_out, bus.rk_valid, last_rk);
            end
        end
        bus.rd_en = 1'b0;
        wait_done(cyc);
        n_checks++;
        if (cyc != 27) begin
            n_fail++;
            $display("FAIL gen_read_latency: key_done after %0d more edges, required 27", cyc);
        end
        build_model(key);
        read_all(1'b1);
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (obs_rk[i] !== exp_rk[i] || obs_v[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL gen_read_sched rk%0d: got %h, required %h", i, obs_rk[i], exp_rk[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [63:0] key_a, key_b;
        int cyc;
        key_a = {$urandom, $urandom};
        key_b = ~key_a;
        start_key(key_a);
        repeat (9) tick();
        bus.start  = 1'b1;
        bus.key_in = key_b;
        tick();
        bus.start = 1'b0;
        wait_done(cyc);
        n_checks++;
        if (cyc != 22) begin
            n_fail++;
            $display("FAIL ignore_latency: key_done after %0d more edges, required 22", cyc);
        end
        build_model(key_a);
        read_all(1'b0);
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (obs_rk[i] !== exp_rk[i] || obs_v[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL ignore_start rk%0d: got %h, required %h", i, obs_rk[i], exp_rk[i]);
            end
        end
    endtask

    task automatic test_reset_mid_gen();
        logic [63:0] key;
        int cyc;
        start_key({$urandom, $urandom});
        repeat (14) tick();
        res_n = 1'b0;
        #1;
        n_checks++;
        if (bus.key_done !== 1'b0 || bus.rk_valid !== 1'b0 || bus.rk_out !== 16'h0) begin
            n_fail++;
            $display("FAIL midgen_reset: key_done=%b rk_valid=%b rk_out=%h, required 0/0/0000",
                     bus.key_done, bus.rk_valid, bus.rk_out);
        end
        tick();
        res_n = 1'b1;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.rd_idx = 5'($urandom_range(0, 31));
            tick();
            n_checks++;
            if (bus.key_done !== 1'b0 || bus.rk_valid !== 1'b0 || bus.rk_out !== 16'h0) begin
                n_fail++;
                $display("FAIL post_reset_idle%0d: key_done=%b rk_valid=%b rk_out=%h, required 0/0/0000",
                         i, bus.key_done, bus.rk_valid, bus.rk_out);
            end
        end
        bus.rd_en = 1'b0;
        key = {$urandom, $urandom};
        start_key(key);
        wait_done(cyc);
        n_checks++;
        if (cyc != 32) begin
            n_fail++;
            $display("FAIL post_reset_latency: key_done after %0d edges, required 32", cyc);
        end
        build_model(key);
        read_all(1'b1);
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (obs_rk[i] !== exp_rk[i] || obs_v[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_sched rk%0d: got %h, required %h", i, obs_rk[i], exp_rk[i]);
            end
        end
    endtask

    task automatic test_read_and_restart();
        logic [63:0] key_b;
        logic [15:0] old_rk;
        int r, cyc;
        r      = $urandom_range(0, 31);
        old_rk = exp_rk[r];
        key_b  = {$urandom, $urandom};
        bus.rd_en  = 1'b1;
        bus.rd_idx = 5'(r);
        bus.start  = 1'b1;
        bus.key_in = key_b;
        tick();
        bus.rd_en = 1'b0;
        bus.start = 1'b0;
        n_checks++;
        if (bus.rk_valid !== 1'b1 || bus.rk_out !== old_rk || bus.key_done !== 1'b0) begin
            n_fail++;
            $display("FAIL read_restart: rk_out=%h valid=%b key_done=%b, required %h valid=1 key_done=0",
                     bus.rk_out, bus.rk_valid, bus.key_done, old_rk);
        end
        wait_done(cyc);
        n_checks++;
        if (cyc != 32) begin
            n_fail++;
            $display("FAIL restart_latency: key_done after %0d edges, required 32", cyc);
        end
        build_model(key_b);
        read_all(1'b0);
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (obs_rk[i] !== exp_rk[i] || obs_v[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL restart_sched rk%0d: got %h, required %h", i, obs_rk[i], exp_rk[i]);
            end
        end
    endtask

    task automatic test_random_keys();
        logic [63:0] key;
        int cyc;
        for (int t = 0; t < 3; t++) begin
            key = {$urandom, $urandom};
            start_key(key);
            wait_done(cyc);
            n_checks++;
            if (cyc != 32) begin
                n_fail++;
                $display("FAIL rand%0d_latency: key_done after %0d edges, required 32", t, cyc);
            end
            build_model(key);
            read_all(t[0]);
            for (int i = 0; i < 32; i++) begin
                n_checks++;
                if (obs_rk[i] !== exp_rk[i] || obs_v[i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand%0d rk%0d: got %h, required %h", t, i, obs_rk[i], exp_rk[i]);
                end
            end
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.key_in = '0;
        bus.rd_en  = 1'b0;
        bus.rd_idx = '0;
        last_rk    = '0;
        test_reset();
        test_latency();
        test_known_vector();
        test_full_read();
        test_read_outside_done();
        test_start_ignored();
        test_reset_mid_gen();
        test_read_and_restart();
        test_random_keys();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
